div_restoring_param: RTL
========================

Name: div_restoring_param

Overview:
- Parametrised, multi-cycle restoring divider.
- Next generation of the fixed 32-bit unsigned divider: configurable width, per-operation signed/unsigned mode, explicit divide-by-zero flag and defined signed-overflow result.
- Sits beside the multiplier in the arithmetic library; consumed by ALU/execute stages through a start/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (legal 4..64).

Ports:
- clk  input  1  rising-edge clock
- n_rst  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  1 = two's-complement operation, 0 = unsigned; sampled with start
- src1  input  WIDTH  dividend; sampled with start
- src2  input  WIDTH  divisor; sampled with start
- qut  output  WIDTH  quotient, registered
- rmd  output  WIDTH  remainder, registered
- done  output  1  one-cycle pulse, results valid
- busy  output  1  high from the accepting edge until the edge that raises done
- div_zero  output  1  registered flag; set with done when src2 was 0, cleared at next accepted start

Behaviour:
- Reset (n_rst low, asynchronous):
  - state = IDLE; qut, rmd, done, busy, div_zero = 0.
  - Reset mid-operation aborts; no done is produced.
- Operand capture:
  - Operands and is_signed are latched at the accepting edge.
  - Later input changes have no effect on the current operation.
- States:
  - IDLE: start=1 -> if src2==0 go ZERO, else latch |src1| and |src2| (magnitudes when signed, raw otherwise), record sign of quotient (s1^s2) and sign of remainder (s1), go CALC; busy=1.
  - CALC: WIDTH iterations, one quotient bit per cycle, MSB first.
    - Partial remainder is WIDTH+1 bits: shift left and bring in the next dividend bit, then trial-subtract the divisor.
    - If the result is non-negative, keep it and set q bit = 1; otherwise restore and set q bit = 0.
    - An iteration counter counts 0..WIDTH-1, then goes to FIX.
  - FIX: negate quotient if its sign flag is set; negate remainder if the dividend was negative. Register qut/rmd, pulse done, clear busy, go IDLE.
  - ZERO: qut = all ones, rmd = src1 (raw), div_zero=1, pulse done, clear busy, go IDLE.
- Latency, counted from the accepting edge E0:
  - Normal: done high after edge E0+WIDTH+1, for one cycle. For WIDTH=32, done is visible 33 edges after E0.
  - Zero divisor: done high after edge E0+1.
- Signed rules:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Invariant: src1 == qut*src2 + rmd (mod 2^WIDTH).
  - Overflow case (MIN / -1): qut = MIN (0x8000_0000 for 32), rmd = 0, div_zero = 0. This falls out of the magnitude datapath; no special state.
- Handshake:
  - start while busy is ignored; it is neither queued nor able to corrupt the operation.
  - start may be asserted in the same cycle that done is high. The FSM is already IDLE then, so the request is accepted, giving back-to-back operations with no gap.
- Outputs hold their last values between operations and are overwritten only at the next FIX/ZERO.
- Unsigned mode must match `/` and `%` for all operands, including src1 < src2 (qut=0, rmd=src1) and src1 == src2 (qut=1, rmd=0).

Test Plan:
- Unsigned, WIDTH=32:
  - src1=0xFFFF_FFFF, src2=0x0000_0010 -> qut=0x0FFF_FFFF, rmd=0xF.
  - done exactly 33 edges after start; busy high throughout.
- Signed, WIDTH=32:
  - -7/2 (0xFFFF_FFF9/0x2) -> qut=0xFFFF_FFFD, rmd=0xFFFF_FFFF.
  - 7/-2 -> qut=0xFFFF_FFFD, rmd=0x1.
  - MIN/-1 -> qut=0x8000_0000, rmd=0.
- Divide by zero:
  - src1=0x1234_5678, src2=0 -> qut=0xFFFF_FFFF, rmd=0x1234_5678, div_zero=1.
  - done 1 edge after start.
  - div_zero clears at the next start.
- Handshake:
  - Re-pulse start and change src1/src2 mid-CALC -> result unchanged; only one done.
  - start asserted in the done cycle -> second operation accepted; its done arrives 33 edges later.
- Reset:
  - Drop n_rst at iteration 10 -> all outputs 0 immediately; no done.
  - After release, a new 100/7 gives qut=14, rmd=2.
- Width sweep: WIDTH=8 instance, 500 random unsigned and 500 random signed pairs checked against `/` and `%` (signed semantics per the rules above) and against the invariant; latency 9 edges.

Source files
------------

// File: rtl/div_restoring_param.sv
// Multi-cycle restoring divider, WIDTH-bit, signed or unsigned per operation.
// Ports: clk, n_rst | start, is_signed, src1, src2 -> qut, rmd, done, busy, div_zero
module div_restoring_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic [WIDTH-1:0] qut,
  output logic [WIDTH-1:0] rmd,
  output logic             done,
  output logic             busy,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    ZERO
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] qut_q, qut_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             dz_q, dz_d;

  logic             s1, s2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   shl, diff;

  assign s1   = is_signed & src1[WIDTH-1];
  assign s2   = is_signed & src2[WIDTH-1];
  assign mag1 = s1 ? -src1 : src1;
  assign mag2 = s2 ? -src2 : src2;

  // dvd_q shifts dividend bits out of its MSB
  // while quotient bits enter at its LSB.
  assign shl  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign diff = shl - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qut_d   = qut_q;
    rmd_d   = rmd_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          dz_d   = 1'b0;
          cnt_d  = '0;
          rem_d  = '0;
          if (src2 == '0) begin
            dvd_d   = src1;
            state_d = ZERO;
          end else begin
            dvd_d   = mag1;
            dvs_d   = mag2;
            qneg_d  = s1 ^ s2;
            rneg_d  = s1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = diff[WIDTH] ? shl : diff;
        dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        qut_d   = qneg_q ? -dvd_q : dvd_q;
        rmd_d   = rneg_q ? -rem_q[WIDTH-1:0]
                         : rem_q[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      ZERO: begin
        qut_d   = '1;
        rmd_d   = dvd_q;
        dz_d    = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qut_q   <= '0;
      rmd_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qut_q   <= qut_d;
      rmd_q   <= rmd_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dz_q    <= dz_d;
    end
  end

  assign qut      = qut_q;
  assign rmd      = rmd_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign div_zero = dz_q;

endmodule
